// File: rtl/fbuf_sprite_writer_if.sv
// Bus bundle between the sprite writer, its sprite ROM and the 1-bpp framebuffer.
// The master side is the writer; the slave side is the draw requester plus memories.
interface fbuf_sprite_writer_if;
    logic        start;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [3:0]  rows;
    logic [3:0]  spr_addr;
    logic [7:0]  spr_data;
    logic [8:0]  fbuf_addr;
    logic [15:0] fbuf_rdata;
    logic [15:0] fbuf_wdata;
    logic        fbuf_we;
    logic        busy;
    logic        done;
    logic        collision;

    modport master (
        input  start, x, y, rows, spr_data, fbuf_rdata,
        output spr_addr, fbuf_addr, fbuf_wdata, fbuf_we, busy, done, collision
    );

    modport slave (
        output start, x, y, rows, spr_data, fbuf_rdata,
        input  spr_addr, fbuf_addr, fbuf_wdata, fbuf_we, busy, done, collision
    );
endinterface

// File: rtl/fbuf_sprite_writer.sv
// XOR-draws an 8-pixel-wide sprite into a 128x64 1-bpp framebuffer of 16-bit words,
// one read-modify-write per touched word, with right/bottom clipping and collision flag.
module fbuf_sprite_writer (
    input  logic                        clk,
    input  logic                        res,
    fbuf_sprite_writer_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE, SPR, RD0, WR0, RD1, WR1, NEXT, DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [6:0]  x_reg, x_next;
    logic [5:0]  y_reg, y_next;
    logic [3:0]  rows_reg, rows_next;
    logic [3:0]  r_reg, r_next;
    logic [7:0]  spr_reg, spr_next;
    logic        coll_reg, coll_next;

    // Row address is always in range when used: NEXT stops before y+r passes 63.
    logic [5:0]  row_addr;
    logic [6:0]  next_row_sum;
    logic [4:0]  r_inc;
    logic [2:0]  col0, col1;
    logic [23:0] win;
    logic [15:0] mask0, mask1, act_mask;
    logic [15:0] wdata_bits, hit_bits;
    logic        need_second;
    logic        last_row;

    assign row_addr     = y_reg + {2'b00, r_reg};
    assign next_row_sum = {1'b0, y_reg} + {3'b000, r_reg} + 7'd1;
    assign r_inc        = {1'b0, r_reg} + 5'd1;
    assign col0         = x_reg[6:4];
    assign col1         = col0 + 3'd1;

    assign win          = {spr_reg, 16'h0000} >> x_reg[3:0];
    assign mask0        = win[23:8];
    assign mask1        = {win[7:0], 8'h00};
    assign act_mask     = (state_reg == RD1 || state_reg == WR1) ? mask1 : mask0;

    // A second word is touched only when the sprite spills past bit 0 and
    // there is a word to the right; word column 8 would be a wrap.
    assign need_second  = (x_reg[3:0] > 4'd8) && (x_reg[6:4] != 3'd7);
    assign last_row     = (r_inc == {1'b0, rows_reg}) || (next_row_sum > 7'd63);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign wdata_bits[gi] = bus.fbuf_rdata[gi] ^ act_mask[gi];
            assign hit_bits[gi]   = bus.fbuf_rdata[gi] & act_mask[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            rows_reg  <= '0;
            r_reg     <= '0;
            spr_reg   <= '0;
            coll_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            rows_reg  <= rows_next;
            r_reg     <= r_next;
            spr_reg   <= spr_next;
            coll_reg  <= coll_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        rows_next      = rows_reg;
        r_next         = r_reg;
        spr_next       = spr_reg;
        coll_next      = coll_reg;
        bus.spr_addr   = r_reg;
        bus.fbuf_addr  = '0;
        bus.fbuf_wdata = '0;
        bus.fbuf_we    = 1'b0;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;
        bus.collision  = coll_reg;

        case (state_reg)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    x_next     = bus.x;
                    y_next     = bus.y;
                    rows_next  = bus.rows;
                    r_next     = '0;
                    coll_next  = 1'b0;
                    state_next = (bus.rows == 4'd0) ? DONE : SPR;
                end
            end
            SPR: begin
                state_next = RD0;
            end
            RD0: begin
                spr_next      = bus.spr_data;
                bus.fbuf_addr = {row_addr, col0};
                state_next    = WR0;
            end
            WR0: begin
                bus.fbuf_addr  = {row_addr, col0};
                bus.fbuf_wdata = wdata_bits;
                bus.fbuf_we    = 1'b1;
                coll_next      = coll_reg | (|hit_bits);
                state_next     = need_second ? RD1 : NEXT;
            end
            RD1: begin
                bus.fbuf_addr = {row_addr, col1};
                state_next    = WR1;
            end
            WR1: begin
                bus.fbuf_addr  = {row_addr, col1};
                bus.fbuf_wdata = wdata_bits;
                bus.fbuf_we    = 1'b1;
                coll_next      = coll_reg | (|hit_bits);
                state_next     = NEXT;
            end
            NEXT: begin
                r_next     = r_inc[3:0];
                state_next = last_row ? DONE : SPR;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fbuf_sprite_writer.sv
// Bench for fbuf_sprite_writer: directed table, reset abort sequence and random draws
// checked against a pixel-level framebuffer model.
module tb_fbuf_sprite_writer;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    fbuf_sprite_writer_if bus();

    fbuf_sprite_writer dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    logic [15:0] fb_mem [512];
    logic [15:0] mfb    [512];
    logic [7:0]  spr_mem [16];
    logic        tb_clr, tb_we;
    logic [8:0]  tb_waddr;
    logic [15:0] tb_wdata;

    // Framebuffer and sprite memories with one-cycle registered reads.
    always_ff @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 512; i++) fb_mem[i] <= '0;
        end else if (tb_we) begin
            fb_mem[tb_waddr] <= tb_wdata;
        end else if (bus.fbuf_we) begin
            fb_mem[bus.fbuf_addr] <= bus.fbuf_wdata;
        end
        bus.fbuf_rdata <= fb_mem[bus.fbuf_addr];
        bus.spr_data   <= spr_mem[bus.spr_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Pixel-level reference: flip every lit sprite pixel that lands on screen.
    task automatic model_draw(input int vx, input int vy, input int vrows,
                              output int n, output int s, output bit coll);
        n = 0; s = 0; coll = 1'b0;
        for (int i = 0; i < vrows; i++) begin
            int yy;
            yy = vy + i;
            if (yy > 63) break;
            n++;
            if ((vx % 16) > 8 && (vx / 16) != 7) s++;
            for (int b = 0; b < 8; b++) begin
                int col, w, bp;
                col = vx + b;
                if (spr_mem[i][7-b] && col <= 127) begin
                    w  = yy * 8 + col / 16;
                    bp = 15 - (col % 16);
                    if (mfb[w][bp]) coll = 1'b1;
                    mfb[w][bp] = ~mfb[w][bp];
                end
            end
        end
    endtask

    function automatic int fb_diffs();
        int d;
        d = 0;
        for (int i = 0; i < 512; i++) if (fb_mem[i] !== mfb[i]) d++;
        return d;
    endfunction

    task automatic clear_fb();
        @(negedge clk); tb_clr = 1'b1;
        @(negedge clk); tb_clr = 1'b0;
        for (int i = 0; i < 512; i++) mfb[i] = '0;
    endtask

    task automatic preset(input int a, input logic [15:0] v);
        @(negedge clk); tb_we = 1'b1; tb_waddr = a[8:0]; tb_wdata = v;
        @(negedge clk); tb_we = 1'b0;
        mfb[a] = v;
    endtask

    task automatic run_draw(input string tag, input int vx, input int vy, input int vrows,
                            output int got_lat, output int got_wr, output bit got_coll);
        int n, s, cyc, bad_rmw, bad_busy, bad_post;
        bit mcoll;
        logic [8:0] prev_addr;
        model_draw(vx, vy, vrows, n, s, mcoll);
        @(negedge clk);
        bus.start = 1'b1; bus.x = vx[6:0]; bus.y = vy[5:0]; bus.rows = vrows[3:0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.x = 7'($urandom); bus.y = 6'($urandom); bus.rows = 4'($urandom);
        got_lat = 0; got_wr = 0; got_coll = 1'b0; cyc = 0;
        bad_rmw = 0; bad_busy = 0; bad_post = 0; prev_addr = '0;
        while (cyc < 300 && got_lat == 0) begin
            @(negedge clk);
            cyc++;
            if (!bus.busy) bad_busy++;
            if (bus.fbuf_we) begin
                got_wr++;
                if (bus.fbuf_addr !== prev_addr) bad_rmw++;
            end
            prev_addr = bus.fbuf_addr;
            if (bus.done) begin
                got_lat  = cyc;
                got_coll = bus.collision;
            end
            // A start pulse while busy must be ignored.
            bus.start = (cyc == 1 && !bus.done) ? 1'b1 : 1'b0;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, got_lat, 4 * n + 1 + 2 * s);
        check({tag, "_writes"}, got_wr, n + s);
        check({tag, "_rmw_and_busy"}, bad_rmw + bad_busy, 0);
        check({tag, "_collision"}, {31'd0, got_coll}, {31'd0, mcoll});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.fbuf_we || bus.collision !== got_coll) bad_post++;
        end
        check({tag, "_post_done"}, bad_post, 0);
        check({tag, "_fb_contents"}, fb_diffs(), 0);
        $display("draw %s x=%0d y=%0d rows=%0d latency=%0d writes=%0d collision=%0d",
                 tag, vx, vy, vrows, got_lat, got_wr, got_coll);
    endtask

    typedef struct {
        int          x;
        int          y;
        int          rows;
        logic [7:0]  spr;
        int          pre_addr;
        logic [15:0] pre_val;
        int          chk_addr;
        logic [15:0] chk_val;
        int          lat;
        int          wr;
        bit          coll;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, wr, cyc, bad;
        bit coll;
        int vx, vy, vr;

        tbl[0] = '{0,   0,  1, 8'hF0, -1, 16'h0000, 0,   16'hF000, 5,  1, 1'b0};
        tbl[1] = '{12,  0,  1, 8'hFF, -1, 16'h0000, 1,   16'hF000, 7,  2, 1'b0};
        tbl[2] = '{0,   0,  1, 8'h80, 0,  16'h8000, 0,   16'h0000, 5,  1, 1'b1};
        tbl[3] = '{124, 0,  1, 8'hFF, 7,  16'h1234, 7,   16'h123B, 5,  1, 1'b1};
        tbl[4] = '{0,   62, 5, 8'hAA, -1, 16'h0000, 504, 16'hAA00, 9,  2, 1'b0};
        tbl[5] = '{5,   9,  0, 8'hFF, -1, 16'h0000, 72,  16'h0000, 1,  0, 1'b0};
        tbl[6] = '{9,   10, 3, 8'hFF, -1, 16'h0000, 81,  16'h8000, 19, 6, 1'b0};
        tbl[7] = '{120, 3,  2, 8'h81, -1, 16'h0000, 31,  16'h0081, 9,  2, 1'b0};

        res = 1'b1; bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.rows = '0;
        tb_clr = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        for (int i = 0; i < 16; i++) spr_mem[i] = '0;
        #1;
        check("reset_outputs",
              {bus.busy, bus.done, bus.fbuf_we, bus.collision, 3'd0, bus.spr_addr},
              32'd0);
        check("reset_bus", {7'd0, bus.fbuf_addr, bus.fbuf_wdata}, 32'd0);
        repeat (3) @(negedge clk);
        res = 1'b0;

        for (int v = 0; v < 8; v++) begin
            clear_fb();
            if (tbl[v].pre_addr >= 0) preset(tbl[v].pre_addr, tbl[v].pre_val);
            for (int i = 0; i < 16; i++) spr_mem[i] = tbl[v].spr;
            run_draw($sformatf("vec%0d", v), tbl[v].x, tbl[v].y, tbl[v].rows, lat, wr, coll);
            check($sformatf("vec%0d_table_latency", v), lat, tbl[v].lat);
            check($sformatf("vec%0d_table_writes", v), wr, tbl[v].wr);
            check($sformatf("vec%0d_table_collision", v), {31'd0, coll}, {31'd0, tbl[v].coll});
            check($sformatf("vec%0d_table_word", v), {16'd0, fb_mem[tbl[v].chk_addr]},
                  {16'd0, tbl[v].chk_val});
        end

        // Reset during WR0 of row 1: row 0 stays written, nothing else happens.
        clear_fb();
        preset(0, 16'h8000);
        for (int i = 0; i < 16; i++) spr_mem[i] = 8'hC0;
        model_draw(0, 0, 1, vx, vy, coll);
        @(negedge clk);
        bus.start = 1'b1; bus.x = 7'd0; bus.y = 6'd0; bus.rows = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (cyc == 6) check("abort_collision_before", {31'd0, bus.collision}, 32'd1);
        end
        check("abort_in_wr0_row1", {22'd0, bus.fbuf_we, bus.fbuf_addr}, {22'd0, 1'b1, 9'd8});
        #1 res = 1'b1;
        #1;
        check("abort_outputs", {28'd0, bus.fbuf_we, bus.busy, bus.collision, bus.done}, 32'd0);
        @(negedge clk);
        res = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.fbuf_we || bus.done || bus.busy) bad++;
        end
        check("abort_quiet_after", bad, 0);
        check("abort_fb_contents", fb_diffs(), 0);
        $display("draw abort x=0 y=0 rows=3 reset in row 1 word 0");
        run_draw("after_abort", 20, 5, 2, lat, wr, coll);

        // Random draws over a persistent framebuffer.
        clear_fb();
        for (int t = 0; t < 30; t++) begin
            vx = $urandom_range(0, 127);
            vy = (t % 4 == 0) ? $urandom_range(56, 63) : $urandom_range(0, 63);
            vr = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) spr_mem[i] = 8'($urandom);
            preset(vy * 8 + vx / 16, 16'($urandom));
            preset($urandom_range(0, 511), 16'($urandom));
            run_draw($sformatf("rnd%0d", t), vx, vy, vr, lat, wr, coll);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
